// File: rtl/dist_ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dist_ram_arb_pkg
// Description : Shared constants and helper functions for the distributed-RAM
//               arbiter: round-robin pick and one-hot to index conversion.
//               Vectors are sized to MAX_REQ so one function body serves any
//               requester count from 2 to MAX_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
package dist_ram_arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;   // enough bits to index MAX_REQ requesters

    // Round-robin search: ptr, ptr+1, ..., num-1, 0, ... ptr-1.
    // Returns a one-hot grant (all zero when no valid bit is set).
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [IDX_W-1:0]   ptr,
        input int                 num
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int                 idx;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= num) begin
                idx = idx - num;
            end
            if ((k < num) && !found && valid[idx[IDX_W-1:0]]) begin
                grant[idx[IDX_W-1:0]] = 1'b1;
                found                 = 1'b1;
            end
        end
        return grant;
    endfunction

    function automatic logic [IDX_W-1:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dist_ram_arbiter_dist_ram_core.sv
`default_nettype none
// ============================================================================
// Module      : dist_ram_core
// Description : Single-write, single-read distributed RAM. Synchronous write,
//               asynchronous read. Contents are never reset.
// Ports       : clock
//               we, waddr, wdata - write port
//               raddr, rdata     - asynchronous read port
// Revision    : 1.0 - initial release
// ============================================================================
module dist_ram_core #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clock,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    (* ram_style = "distributed" *) logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/dist_ram_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter with its own priority pointer. The grant
//               is combinational from valid and the pointer; the pointer
//               moves one past the granted index when the grant is accepted.
// Ports       : clock, reset (async, active-high)
//               valid  [NUM_REQ] - request vector
//               accept           - the current grant is taken this cycle
//               grant  [NUM_REQ] - one-hot grant, zero when nothing valid
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import dist_ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_next_ptr;
    logic [MAX_REQ-1:0] w_pick;
    logic [IDX_W-1:0]   w_gidx;

    assign w_pick = rr_pick(MAX_REQ'(valid), IDX_W'(r_ptr), NUM_REQ);
    assign grant  = w_pick[NUM_REQ-1:0];
    assign w_gidx = onehot2idx(w_pick);

    always_comb begin
        w_next_ptr = r_ptr;
        if (int'(w_gidx) == NUM_REQ - 1) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = PTR_W'(w_gidx + IDX_W'(1));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (accept) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dist_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dist_ram_arbiter
// Description : Shares one distributed RAM (1 write port, 1 async read port)
//               between NUM_REQ requesters using independent round-robin
//               arbiters for writes and reads. Read data is registered
//               (1-cycle latency) and tagged with a one-hot rsp_valid.
//               Optional macro DIST_RAM_ARB_WR_FWD_EN: a same-cycle write and
//               read to the same address returns the new write data.
// Ports       : clock, reset (async, active-high)
//               wr_valid/wr_ready/wr_addr/wr_data - write request channel
//               rd_valid/rd_ready/rd_addr         - read request channel
//               rsp_valid/rsp_data                - read response
// Revision    : 1.0 - initial release
// ============================================================================
module dist_ram_arbiter
    import dist_ram_arb_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int RAM_WIDTH     = 16,
    parameter int RAM_ADDR_BITS = 10
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               wr_valid,
    output logic [NUM_REQ-1:0]               wr_ready,
    input  logic [NUM_REQ*RAM_ADDR_BITS-1:0] wr_addr,
    input  logic [NUM_REQ*RAM_WIDTH-1:0]     wr_data,
    input  logic [NUM_REQ-1:0]               rd_valid,
    output logic [NUM_REQ-1:0]               rd_ready,
    input  logic [NUM_REQ*RAM_ADDR_BITS-1:0] rd_addr,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [RAM_WIDTH-1:0]             rsp_data
);

    logic                     w_wr_en;
    logic                     w_rd_en;
    logic [RAM_ADDR_BITS-1:0] w_wr_addr;
    logic [RAM_WIDTH-1:0]     w_wr_data;
    logic [RAM_ADDR_BITS-1:0] w_rd_addr;
    logic [RAM_WIDTH-1:0]     w_ram_rdata;
    logic [RAM_WIDTH-1:0]     w_rsp_next;
    logic [NUM_REQ-1:0]       r_rsp_valid;
    logic [RAM_WIDTH-1:0]     r_rsp_data;

    // A grant is only ever given to a valid requester, so any grant is
    // an accepted transfer.
    assign w_wr_en = |wr_ready;
    assign w_rd_en = |rd_ready;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
        .clock  (clock),
        .reset  (reset),
        .valid  (wr_valid),
        .accept (w_wr_en),
        .grant  (wr_ready)
    );

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
        .clock  (clock),
        .reset  (reset),
        .valid  (rd_valid),
        .accept (w_rd_en),
        .grant  (rd_ready)
    );

    // One-hot grants make an AND-OR mux of the flattened slices sufficient.
    always_comb begin
        w_wr_addr = '0;
        w_wr_data = '0;
        w_rd_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wr_ready[i]) begin
                w_wr_addr = w_wr_addr | wr_addr[i*RAM_ADDR_BITS +: RAM_ADDR_BITS];
                w_wr_data = w_wr_data | wr_data[i*RAM_WIDTH +: RAM_WIDTH];
            end
            if (rd_ready[i]) begin
                w_rd_addr = w_rd_addr | rd_addr[i*RAM_ADDR_BITS +: RAM_ADDR_BITS];
            end
        end
    end

    dist_ram_core #(
        .WIDTH     (RAM_WIDTH),
        .ADDR_BITS (RAM_ADDR_BITS)
    ) u_ram (
        .clock (clock),
        .we    (w_wr_en),
        .waddr (w_wr_addr),
        .wdata (w_wr_data),
        .raddr (w_rd_addr),
        .rdata (w_ram_rdata)
    );

`ifdef DIST_RAM_ARB_WR_FWD_EN
    // Write-first: a colliding same-cycle write supplies the response data.
    assign w_rsp_next = (w_wr_en && w_rd_en && (w_wr_addr == w_rd_addr)) ?
                        w_wr_data : w_ram_rdata;
`else
    // Read-first: the async read sees the array before this edge's write.
    assign w_rsp_next = w_ram_rdata;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= rd_ready;
            if (w_rd_en) begin
                r_rsp_data <= w_rsp_next;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_dist_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dist_ram_arbiter
// Description : Self-checking bench for dist_ram_arbiter with 4 requesters.
//               Directed grant table, hand-written RAM sequences and random
//               held-request traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dist_ram_arbiter;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 16;

    logic              clk;
    logic              rst;
    logic [N-1:0]      wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid;
    logic [N*AW-1:0]   wr_addr, rd_addr;
    logic [N*DW-1:0]   wr_data;
    logic [DW-1:0]     rsp_data;

    logic [N-1:0]      wv, rv;
    logic [AW-1:0]     wa [N];
    logic [AW-1:0]     ra [N];
    logic [DW-1:0]     wd [N];

    dist_ram_arbiter #(.NUM_REQ(N), .RAM_WIDTH(DW), .RAM_ADDR_BITS(AW)) dut (
        .clock     (clk),
        .reset     (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        wr_addr  = '0;
        rd_addr  = '0;
        wr_data  = '0;
        wr_valid = wv;
        rd_valid = rv;
        for (int i = 0; i < N; i++) begin
            wr_addr[i*AW +: AW] = wa[i];
            rd_addr[i*AW +: AW] = ra[i];
            wr_data[i*DW +: DW] = wd[i];
        end
    end

    // ---------------- checking ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int           m_wptr, m_rptr;
    logic [DW-1:0] m_mem [1024];
    bit           m_known [1024];
    logic [N-1:0] exp_rv;
    logic [DW-1:0] exp_rd;
    bit           exp_rd_known;
    int           last_gw, last_gr;
    logic [N-1:0] dut_wg, dut_rg;

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_wptr       = 0;
        m_rptr       = 0;
        exp_rv       = '0;
        exp_rd       = '0;
        exp_rd_known = 1'b1;
    endfunction

    // Called at posedge+1 with inputs already set; returns at next posedge+1.
    task automatic run_cycle();
        int gw, gr;
        #1;
        gw = pick(wv, m_wptr);
        gr = pick(rv, m_rptr);
        dut_wg = wr_ready;
        dut_rg = rd_ready;
        chk("wr_ready", 32'(wr_ready), (gw < 0) ? 32'd0 : (32'd1 << gw));
        chk("rd_ready", 32'(rd_ready), (gr < 0) ? 32'd0 : (32'd1 << gr));
        exp_rv = '0;
        if (gr >= 0) begin
            exp_rv       = N'(1 << gr);
            exp_rd       = m_mem[ra[gr]];
            exp_rd_known = m_known[ra[gr]];
`ifdef DIST_RAM_ARB_WR_FWD_EN
            if (gw >= 0 && wa[gw] == ra[gr]) begin
                exp_rd       = wd[gw];
                exp_rd_known = 1'b1;
            end
`endif
            m_rptr = (gr + 1) % N;
        end
        if (gw >= 0) begin
            m_mem[wa[gw]]   = wd[gw];
            m_known[wa[gw]] = 1'b1;
            m_wptr          = (gw + 1) % N;
        end
        last_gw = gw;
        last_gr = gr;
        @(posedge clk);
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rd_known) chk("rsp_data", 32'(rsp_data), 32'(exp_rd));
    endtask

    task automatic idle_inputs();
        wv = '0;
        rv = '0;
        for (int i = 0; i < N; i++) begin
            wa[i] = '0; ra[i] = '0; wd[i] = '0;
        end
    endtask

    typedef struct {
        logic [N-1:0] wv;
        logic [N-1:0] rv;
        logic [N-1:0] ewr;
        logic [N-1:0] erd;
    } vec_t;

    vec_t tbl [12];
    int   wwait [N];
    int   rwait [N];

    initial begin
        // Grant sequence from a fresh reset (both pointers at 0).
        tbl[0]  = '{4'b0011, 4'b0011, 4'b0001, 4'b0001};
        tbl[1]  = '{4'b0011, 4'b0011, 4'b0010, 4'b0010};
        tbl[2]  = '{4'b0011, 4'b0011, 4'b0001, 4'b0001};
        tbl[3]  = '{4'b0011, 4'b0011, 4'b0010, 4'b0010};
        tbl[4]  = '{4'b0011, 4'b0011, 4'b0001, 4'b0001};
        tbl[5]  = '{4'b0011, 4'b0011, 4'b0010, 4'b0010};
        tbl[6]  = '{4'b0010, 4'b0010, 4'b0010, 4'b0010};
        tbl[7]  = '{4'b0010, 4'b0010, 4'b0010, 4'b0010};
        tbl[8]  = '{4'b0010, 4'b0010, 4'b0010, 4'b0010};
        tbl[9]  = '{4'b0011, 4'b0011, 4'b0001, 4'b0001};
        tbl[10] = '{4'b1000, 4'b0100, 4'b1000, 4'b0100};
        tbl[11] = '{4'b1111, 4'b1111, 4'b0001, 4'b1000};

        for (int i = 0; i < 1024; i++) begin
            m_mem[i]   = '0;
            m_known[i] = 1'b0;
        end
        idle_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);

        // Idle: no grants, no responses.
        for (int c = 0; c < 5; c++) run_cycle();

        // Table-driven grant sequence.
        for (int r = 0; r < 12; r++) begin
            wv = tbl[r].wv;
            rv = tbl[r].rv;
            for (int i = 0; i < N; i++) begin
                wa[i] = AW'(10'h100 + i);
                wd[i] = DW'(r * 16 + i);
                ra[i] = AW'(10'h100 + i);
            end
            #1;
            chk($sformatf("tbl%0d_wr_ready", r), 32'(wr_ready), 32'(tbl[r].ewr));
            chk($sformatf("tbl%0d_rd_ready", r), 32'(rd_ready), 32'(tbl[r].erd));
            run_cycle();
        end
        idle_inputs();
        run_cycle();

        // Fresh reset, then write 0x005 from r0 and read it back from r1.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        wv = 4'b0001; wa[0] = 10'h005; wd[0] = 16'hBEEF;
        run_cycle();
        wv = '0; rv = 4'b0010; ra[1] = 10'h005;
        #1;
        chk("seq005_rd_ready", 32'(rd_ready), 32'h2);
        run_cycle();
        chk("seq005_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("seq005_rsp_data", 32'(rsp_data), 32'hBEEF);

        // Same-cycle write/read collision at 0x010 (old value 0x0000).
        rv = '0; wv = 4'b0001; wa[0] = 10'h010; wd[0] = 16'h0000;
        run_cycle();
        wv = 4'b0001; wa[0] = 10'h010; wd[0] = 16'h1234;
        rv = 4'b0010; ra[1] = 10'h010;
        run_cycle();
`ifdef DIST_RAM_ARB_WR_FWD_EN
        chk("collide_rsp_data", 32'(rsp_data), 32'h1234);
`else
        chk("collide_rsp_data", 32'(rsp_data), 32'h0000);
`endif

        // Reset in the middle of a read burst.
        wv = '0; rv = 4'b0001; ra[0] = 10'h005;
        run_cycle();
        chk("burst_rsp_valid", 32'(rsp_valid), 32'h1);
        rv = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_rsp_data", 32'(rsp_data), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Committed write survives the reset.
        rv = 4'b0010; ra[1] = 10'h005;
        run_cycle();
        chk("after_rst_data", 32'(rsp_data), 32'hBEEF);
        idle_inputs();
        run_cycle();

        // Random held-request traffic.
        for (int i = 0; i < N; i++) begin
            wwait[i] = 0; rwait[i] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            run_cycle();
            chk("wr_onehot", 32'($countones(dut_wg) <= 1), 32'd1);
            chk("rd_onehot", 32'($countones(dut_rg) <= 1), 32'd1);
            for (int i = 0; i < N; i++) begin
                if (wv[i] && !dut_wg[i]) wwait[i]++; else wwait[i] = 0;
                if (rv[i] && !dut_rg[i]) rwait[i]++; else rwait[i] = 0;
                if (wv[i]) chk("wr_wait", 32'(wwait[i] <= N - 1), 32'd1);
                if (rv[i]) chk("rd_wait", 32'(rwait[i] <= N - 1), 32'd1);
                if (last_gw == i) wv[i] = 1'b0;
                if (last_gr == i) rv[i] = 1'b0;
                if (!wv[i] && ($urandom_range(0, 1) == 1)) begin
                    wv[i] = 1'b1;
                    wa[i] = AW'($urandom_range(0, 15));
                    wd[i] = DW'($urandom);
                end
                if (!rv[i] && ($urandom_range(0, 1) == 1)) begin
                    rv[i] = 1'b1;
                    ra[i] = AW'($urandom_range(0, 15));
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dist_ram_arbiter.md
Name: dist_ram_arbiter

Overview:
- Shares one single-write-port, single-async-read-port distributed RAM between NUM_REQ requesters.
- Runs two independent round-robin arbiters, one for the write port and one for the read port. Each cycle it can accept one write and one read, from the same or different requesters.
- Read data is registered, giving fixed 1-cycle latency, and is steered back to the requester that issued the read.
- Sits between the layer engines and the feature-map scratch RAMs.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- RAM_WIDTH, 16, data word width.
- RAM_ADDR_BITS, 10, address width; depth = 2**RAM_ADDR_BITS.

Ports:
- clock  in  1  single clock; all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- wr_valid  in  NUM_REQ  per-requester write request.
- wr_ready  out  NUM_REQ  one-hot write grant; a write is accepted when wr_valid[i] and wr_ready[i] are both high.
- wr_addr  in  NUM_REQ*RAM_ADDR_BITS  flattened write addresses; requester i uses slice i.
- wr_data  in  NUM_REQ*RAM_WIDTH  flattened write data.
- rd_valid  in  NUM_REQ  per-requester read request.
- rd_ready  out  NUM_REQ  one-hot read grant.
- rd_addr  in  NUM_REQ*RAM_ADDR_BITS  flattened read addresses.
- rsp_valid  out  NUM_REQ  one-hot; pulses 1 cycle after an accepted read.
- rsp_data  out  RAM_WIDTH  read data, shared by all requesters; qualified by rsp_valid.

Behaviour:
- Reset (asynchronous, active-high):
  - rsp_valid = 0, rsp_data = 0.
  - wr_ptr = 0, rd_ptr = 0, so requester 0 has top priority after reset.
  - RAM contents are not reset.
- Grants:
  - wr_ready and rd_ready are combinational from the valids and the pointers.
  - At most one bit of each is set; they are all-zero when no valid is high.
  - Requesters must not make valid depend on ready.
- Round-robin:
  - Search starts at index ptr, then ptr+1, … up to NUM_REQ-1, then wraps to 0.
  - The first valid index found is granted.
  - On an accepted grant to index g, ptr <= (g == NUM_REQ-1) ? 0 : g+1.
  - If nothing is granted, ptr holds.
- Write: on an accepted write, RAM[wr_addr slice g] <= wr_data slice g at the clock edge.
- Read:
  - On an accepted read from index g, at the clock edge: rsp_data <= RAM[rd_addr slice g] and rsp_valid <= onehot(g).
  - In cycles with no accepted read, rsp_valid <= 0 and rsp_data holds its last value.
- Read latency is exactly 1 cycle. There is no backpressure on responses.
- Requests are held: a valid not granted this cycle stays asserted with stable addr/data until accepted. The arbiter does not check this.
- Same-cycle write and read to the same address (any requesters):
  - without the option below, the response returns OLD data;
  - with it, the response returns NEW data.
- Simultaneous wr_valid and rd_valid from one requester: both may be granted in the same cycle; the two arbiters are independent.
- A reset asserted mid-operation:
  - drops any in-flight response (rsp_valid forced to 0);
  - restores both pointers to 0;
  - does not undo writes already committed.
- Widths:
  - Pointers are $clog2(NUM_REQ) bits, with a minimum of 1.
  - Flattened slices are [i*W +: W].

Optional Feature:
- Macro: DIST_RAM_ARB_WR_FWD_EN.
- Defined: if a read and a write are both accepted in the same cycle and the selected addresses are equal, rsp_data <= the selected wr_data (write-first bypass).
- Undefined: rsp_data always comes from the RAM array (read-first / old data). No bypass comparator is synthesised.

Decomposition:
- Package dist_ram_arb_pkg holds:
  - function rr_pick(valid, ptr), returning a one-hot grant;
  - function onehot2idx;
  - localparam MAX_REQ = 8.
- Natural sub-module: rr_arbiter (valid vector + accept in, one-hot grant out, owns its pointer), instantiated twice.
- The RAM array is a second sub-module, dist_ram_core: asynchronous read, synchronous write, ram_style "distributed".

Test Plan:
- Reset, then all valids = 0 -> wr_ready = 0, rd_ready = 0, rsp_valid = 0 for 5 cycles; assert reset mid-burst -> rsp_valid drops the same cycle.
- Requester 0 writes addr 0x005 data 0xBEEF, next cycle requester 1 reads 0x005 -> rd_ready = 2'b10, and the following cycle rsp_valid = 2'b10, rsp_data = 0xBEEF.
- Both requesters hold wr_valid for 6 cycles after reset -> wr_ready sequence 01, 10, 01, 10, 01, 10; each requester gets exactly 3 grants.
- Only requester 1 is valid for 3 cycles -> granted every cycle (no idle bubble); then both valid -> requester 0 is granted next.
- Same cycle: requester 0 writes 0x010 = 0x1234 (old value 0x0000) and requester 1 reads 0x010 -> rsp_data = 0x0000 without the macro, 0x1234 with DIST_RAM_ARB_WR_FWD_EN.
- Random traffic with NUM_REQ = 4 against a scoreboard model for 10k cycles -> every read matches the model, grants are never multi-hot, and no requester waits more than NUM_REQ-1 cycles.
